ifu_next_pc: RTL and testbench
==============================

Name: ifu_next_pc

Overview:
- Fetch-side consumer of the D-stage branch decision. Owns the F-stage PC register and computes the next PC.
- Sources for the next PC: sequential PC+4, taken conditional branch (`br`), j/jal, jr/jalr, eret return, and exception entry.
- Also produces the delay-slot flag for the instruction being fetched and the F-stage address-error flag used by the exception pipeline.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_ENTRY, 32'h0000_4180, exception handler entry address.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall; freezes the PC.
- is_br  in  1  D-stage instruction is a conditional branch.
- br  in  1  branch taken, from the D-stage comparator (already qualified by is_br).
- jump  in  1  D-stage instruction is j/jal.
- jr  in  1  D-stage instruction is jr/jalr.
- eret  in  1  D-stage instruction is eret.
- pc_d  in  32  PC of the D-stage instruction.
- imm16  in  16  branch offset field of the D-stage instruction.
- index26  in  26  jump index field of the D-stage instruction.
- rs_val  in  32  forwarded rs value (jr target).
- exc_req  in  1  exception/interrupt accepted; pipeline flush.
- epc  in  32  CP0 EPC value (eret target).
- pc_f  out  32  current fetch PC (registered).
- bd_f  out  1  fetched instruction is in a delay slot (registered).
- adel_f  out  1  fetch address error (combinational from pc_f).
- flush_d  out  1  squash the instruction entering D (eret has no delay slot).

Behaviour:
- Reset, asynchronous, active-high: pc_f=RESET_PC, bd_f=0. As a consequence adel_f=0 and flush_d=0.
- Reset mid-operation overrides any pending redirect. The first fetch after reset release is RESET_PC.
- Registered next-PC selection, priority highest first:
  1. exc_req: pc_f<=EXC_ENTRY, bd_f<=0. Wins even if stall=1.
  2. stall: pc_f and bd_f hold. eret held in D is not acted on; flush_d=0.
  3. eret: pc_f<=epc, bd_f<=0.
  4. jr: pc_f<=rs_val.
  5. jump: pc_f<={pc_d[31:28], index26, 2'b00}.
  6. is_br&br: pc_f<=pc_d+4+{{14{imm16[15]}},imm16,2'b00}, 32-bit modular wrap.
  7. otherwise: pc_f<=pc_f+4, 32-bit wrap.
- bd_f update on any non-stalled, non-exception, non-eret advance: bd_f<=is_br|jump|jr.
  - bd_f is set whether or not the branch is taken; it marks the slot after the control-transfer instruction.
- flush_d = eret & ~stall & ~exc_req (combinational).
- adel_f = (pc_f[1:0]!=0) | (pc_f<IM_BASE) | (pc_f>IM_LIMIT), unsigned compares.
  - The block keeps fetching on an error; the exception pipeline raises exc_req later.
- Simultaneous jump and is_br never legally occur. If they do, the priority order above applies; no assertion inside the block.
- Latency: a redirect decided in D is visible on pc_f in the next cycle (one delay slot).
- Back-to-back control transfers: a branch in a delay slot follows normal priority.

Decomposition:
- Shared define file holds RESET_PC/EXC_ENTRY/IM_BASE/IM_LIMIT defaults and the opcode/funct constants already used by the decoder.
- One sub-module, ifu_target_calc: purely combinational branch/jump/jr target computation, instantiated once.
- The PC/bd_f register and the priority mux stay in ifu_next_pc.

Test Plan:
- Reset held, then released -> pc_f=0x3000, bd_f=0. Next three cycles pc_f=0x3004, 0x3008, 0x300C.
- pc_d=0x3010, is_br=1, br=1, imm16=0xFFFC -> next pc_f=0x3004, bd_f=1. Repeat with br=0 -> pc_f=previous+4, bd_f=1.
- pc_d=0x3020, jump=1, index26=0x0000C10 -> pc_f=0x3040. Then jr=1, rs_val=0x3101 -> pc_f=0x3101, adel_f=1.
- stall=1 for 3 cycles with br=1 pending -> pc_f and bd_f frozen. On stall release, redirect is taken in the following cycle.
- exc_req=1 with stall=1 and jump=1 -> pc_f=0x4180, bd_f=0. eret=1, epc=0x3050 -> flush_d=1 that cycle, pc_f=0x3050 next.
- Async reset asserted mid-cycle while pc_f=0x3400 -> pc_f=0x3000 immediately, before the next clock edge.

Source files
------------

// File: rtl/ifu_next_pc_pkg.sv
// Shared constants and types for the fetch-side next-PC logic.
// Holds the address map defaults, decoder opcode/funct values and the next-PC source encoding.
package ifu_next_pc_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;
  localparam logic [31:0] IM_BASE_DEF   = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT_DEF  = 32'h0000_6FFC;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_COP0     = 6'h10;
  localparam logic [5:0] FUNCT_JR    = 6'h08;
  localparam logic [5:0] FUNCT_JALR  = 6'h09;
  localparam logic [5:0] FUNCT_ERET  = 6'h18;

  typedef enum logic [2:0] {
    SEL_EXC  = 3'd0,
    SEL_HOLD = 3'd1,
    SEL_ERET = 3'd2,
    SEL_JR   = 3'd3,
    SEL_JUMP = 3'd4,
    SEL_BR   = 3'd5,
    SEL_SEQ  = 3'd6
  } npc_sel_e;

  function automatic logic fetch_addr_err(input logic [31:0] pc,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
    return (pc[1:0] != 2'b00) | (pc < lo) | (pc > hi);
  endfunction

endpackage

// File: rtl/ifu_next_pc_if.sv
// D-stage control inputs and F-stage outputs exchanged with the next-PC block.
interface ifu_next_pc_if;
  logic        stall;
  logic        is_br;
  logic        br;
  logic        jump;
  logic        jr;
  logic        eret;
  logic [31:0] pc_d;
  logic [15:0] imm16;
  logic [25:0] index26;
  logic [31:0] rs_val;
  logic        exc_req;
  logic [31:0] epc;
  logic [31:0] pc_f;
  logic        bd_f;
  logic        adel_f;
  logic        flush_d;

  modport master (
    output stall, is_br, br, jump, jr, eret, pc_d, imm16, index26, rs_val, exc_req, epc,
    input  pc_f, bd_f, adel_f, flush_d
  );

  modport slave (
    input  stall, is_br, br, jump, jr, eret, pc_d, imm16, index26, rs_val, exc_req, epc,
    output pc_f, bd_f, adel_f, flush_d
  );
endinterface

// File: rtl/ifu_target_calc.sv
// Combinational control-transfer targets for the instruction sitting in D.
module ifu_target_calc (
  input  logic [31:0] pc_d,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] rs_val,
  output logic [31:0] br_target,
  output logic [31:0] j_target,
  output logic [31:0] jr_target
);

  // Branch offset is relative to the delay-slot address and wraps modulo 2^32.
  assign br_target = pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_target  = {pc_d[31:28], index26, 2'b00};
  assign jr_target = rs_val;

endmodule

// File: rtl/ifu_next_pc.sv
// F-stage PC register with prioritised next-PC selection, delay-slot flag,
// fetch address-error detection and the eret squash signal for D.
module ifu_next_pc
  import ifu_next_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF,
  parameter logic [31:0] IM_BASE   = IM_BASE_DEF,
  parameter logic [31:0] IM_LIMIT  = IM_LIMIT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  ifu_next_pc_if.slave bus
);

  logic [31:0] pc_r;
  logic        bd_r;
  logic [31:0] pc_next_s;
  logic        bd_next_s;
  logic [31:0] br_target_s;
  logic [31:0] j_target_s;
  logic [31:0] jr_target_s;
  npc_sel_e    sel_s;

  ifu_target_calc u_target_calc (
    .pc_d      (bus.pc_d),
    .imm16     (bus.imm16),
    .index26   (bus.index26),
    .rs_val    (bus.rs_val),
    .br_target (br_target_s),
    .j_target  (j_target_s),
    .jr_target (jr_target_s)
  );

  // Source priority: exception beats stall, so a flush can never be frozen out.
  always_comb begin
    sel_s = SEL_SEQ;
    if (bus.exc_req) begin
      sel_s = SEL_EXC;
    end else if (bus.stall) begin
      sel_s = SEL_HOLD;
    end else if (bus.eret) begin
      sel_s = SEL_ERET;
    end else if (bus.jr) begin
      sel_s = SEL_JR;
    end else if (bus.jump) begin
      sel_s = SEL_JUMP;
    end else if (bus.is_br & bus.br) begin
      sel_s = SEL_BR;
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  // Next PC and delay-slot flag; a not-taken branch still marks its slot.
  always_comb begin
    pc_next_s = pc_r + 32'd4;
    bd_next_s = bus.is_br | bus.jump | bus.jr;
    case (sel_s)
      SEL_EXC: begin
        pc_next_s = EXC_ENTRY;
        bd_next_s = 1'b0;
      end
      SEL_HOLD: begin
        pc_next_s = pc_r;
        bd_next_s = bd_r;
      end
      SEL_ERET: begin
        pc_next_s = bus.epc;
        bd_next_s = 1'b0;
      end
      SEL_JR:   pc_next_s = jr_target_s;
      SEL_JUMP: pc_next_s = j_target_s;
      SEL_BR:   pc_next_s = br_target_s;
      SEL_SEQ:  pc_next_s = pc_r + 32'd4;
      default:  pc_next_s = pc_r + 32'd4;
    endcase
  end

  // PC and delay-slot state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_PC;
      bd_r <= 1'b0;
    end else begin
      pc_r <= pc_next_s;
      bd_r <= bd_next_s;
    end
  end

  assign bus.pc_f    = pc_r;
  assign bus.bd_f    = bd_r;
  assign bus.adel_f  = fetch_addr_err(pc_r, IM_BASE, IM_LIMIT);
  // eret has no delay slot, so the instruction behind it must not reach D.
  assign bus.flush_d = bus.eret & ~bus.stall & ~bus.exc_req;

endmodule

// File: tb/tb_ifu_next_pc.sv
// Directed-vector bench for ifu_next_pc with hand-computed expected values.
module tb_ifu_next_pc;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ifu_next_pc_if bus ();

  ifu_next_pc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic clr();
    bus.stall   = 1'b0;
    bus.is_br   = 1'b0;
    bus.br      = 1'b0;
    bus.jump    = 1'b0;
    bus.jr      = 1'b0;
    bus.eret    = 1'b0;
    bus.pc_d    = 32'h0000_0000;
    bus.imm16   = 16'h0000;
    bus.index26 = 26'h000_0000;
    bus.rs_val  = 32'h0000_0000;
    bus.exc_req = 1'b0;
    bus.epc     = 32'h0000_0000;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jr_to(input logic [31:0] tgt);
    clr();
    bus.jr     = 1'b1;
    bus.rs_val = tgt;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clr();
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", bus.pc_f, 32'h0000_3000);
    check("rst_bd", {31'd0, bus.bd_f}, 32'd0);
    check("rst_adel", {31'd0, bus.adel_f}, 32'd0);
    check("rst_flush", {31'd0, bus.flush_d}, 32'd0);

    reset = 1'b0;
    #1;
    check("rel_pc", bus.pc_f, 32'h0000_3000);
    step(); check("seq1", bus.pc_f, 32'h0000_3004);
    step(); check("seq2", bus.pc_f, 32'h0000_3008);
    step(); check("seq3", bus.pc_f, 32'h0000_300C);

    bus.pc_d = 32'h0000_3010; bus.is_br = 1'b1; bus.br = 1'b1; bus.imm16 = 16'hFFFC;
    step();
    check("br_taken_pc", bus.pc_f, 32'h0000_3004);
    check("br_taken_bd", {31'd0, bus.bd_f}, 32'd1);
    bus.br = 1'b0;
    step();
    check("br_nt_pc", bus.pc_f, 32'h0000_3008);
    check("br_nt_bd", {31'd0, bus.bd_f}, 32'd1);

    clr(); bus.jump = 1'b1; bus.pc_d = 32'h0000_3020; bus.index26 = 26'h000_0C10;
    step();
    check("j_pc", bus.pc_f, 32'h0000_3040);
    check("j_bd", {31'd0, bus.bd_f}, 32'd1);
    jr_to(32'h0000_3101);
    check("jr_pc", bus.pc_f, 32'h0000_3101);
    check("jr_adel", {31'd0, bus.adel_f}, 32'd1);

    clr(); bus.stall = 1'b1; bus.is_br = 1'b1; bus.br = 1'b1;
    bus.pc_d = 32'h0000_3200; bus.imm16 = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", bus.pc_f, 32'h0000_3101);
      check("stall_bd", {31'd0, bus.bd_f}, 32'd1);
    end
    bus.stall = 1'b0;
    step();
    check("unstall_pc", bus.pc_f, 32'h0000_3244);
    check("unstall_bd", {31'd0, bus.bd_f}, 32'd1);
    clr();
    step();
    check("post_pc", bus.pc_f, 32'h0000_3248);
    check("post_bd", {31'd0, bus.bd_f}, 32'd0);

    bus.exc_req = 1'b1; bus.stall = 1'b1; bus.jump = 1'b1; bus.eret = 1'b1;
    bus.index26 = 26'h000_0D00;
    #1;
    check("exc_flush", {31'd0, bus.flush_d}, 32'd0);
    step();
    check("exc_pc", bus.pc_f, 32'h0000_4180);
    check("exc_bd", {31'd0, bus.bd_f}, 32'd0);
    check("exc_adel", {31'd0, bus.adel_f}, 32'd0);

    clr(); bus.eret = 1'b1; bus.epc = 32'h0000_3050;
    #1;
    check("eret_flush", {31'd0, bus.flush_d}, 32'd1);
    step();
    check("eret_pc", bus.pc_f, 32'h0000_3050);
    check("eret_bd", {31'd0, bus.bd_f}, 32'd0);
    bus.stall = 1'b1; bus.epc = 32'h0000_3500;
    #1;
    check("eret_stall_flush", {31'd0, bus.flush_d}, 32'd0);
    step();
    check("eret_stall_pc", bus.pc_f, 32'h0000_3050);

    jr_to(32'h0000_6FFC); check("lim_ok", {31'd0, bus.adel_f}, 32'd0);
    jr_to(32'h0000_7000); check("lim_over", {31'd0, bus.adel_f}, 32'd1);
    jr_to(32'h0000_2FFC); check("base_under", {31'd0, bus.adel_f}, 32'd1);
    jr_to(32'h0000_3000); check("base_ok", {31'd0, bus.adel_f}, 32'd0);
    jr_to(32'hFFFF_FFFC);
    clr();
    step();
    check("seq_wrap_pc", bus.pc_f, 32'h0000_0000);
    check("seq_wrap_bd", {31'd0, bus.bd_f}, 32'd0);

    bus.is_br = 1'b1; bus.br = 1'b1; bus.pc_d = 32'h0000_3000; bus.imm16 = 16'h8000;
    step();
    check("br_neg_pc", bus.pc_f, 32'hFFFE_3004);

    clr(); bus.jr = 1'b1; bus.jump = 1'b1; bus.is_br = 1'b1; bus.br = 1'b1;
    bus.rs_val = 32'h0000_3300; bus.pc_d = 32'h0000_3000; bus.index26 = 26'h000_0001;
    step();
    check("prio_jr", bus.pc_f, 32'h0000_3300);
    clr(); bus.jump = 1'b1; bus.is_br = 1'b1; bus.br = 1'b1;
    bus.pc_d = 32'h0000_3000; bus.index26 = 26'h000_0D00; bus.imm16 = 16'h0004;
    step();
    check("prio_jump", bus.pc_f, 32'h0000_3400);
    check("prio_bd", {31'd0, bus.bd_f}, 32'd1);

    #3;
    reset = 1'b1;
    #1;
    check("async_rst_pc", bus.pc_f, 32'h0000_3000);
    check("async_rst_bd", {31'd0, bus.bd_f}, 32'd0);
    step();
    check("rst_hold_pc", bus.pc_f, 32'h0000_3000);
    reset = 1'b0;
    clr();
    step();
    check("rst_after_pc", bus.pc_f, 32'h0000_3004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
